// File: rtl/contador_mod_n.sv
// Parametrised modulo-N up/down counter with clear, clamped load, wrap/saturate
// select and a sticky overflow flag; oTC is enable-gated for direct cascading.
module contador_mod_n #(
   parameter int WIDTH  = 4,
   parameter int MODULO = 10
) (
   input  logic             iCLOCK,
   input  logic             iRESET_n,
   input  logic             iENABLE,
   input  logic             iUP_DOWN,
   input  logic             iCLEAR,
   input  logic             iLOAD,
   input  logic [WIDTH-1:0] iLOAD_VALUE,
   input  logic             iSATURATE,
   output logic [WIDTH-1:0] oCOUNT,
   output logic             oTC,
   output logic             oOVERFLOW
);

   if ((MODULO < 2) || (longint'(MODULO) > (longint'(1) << WIDTH))) begin : g_bad_modulo
      $fatal(1, "contador_mod_n: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] term;
   logic             at_term;
   logic [WIDTH-1:0] load_clamped;

   // Explicit compare against MODULO-1 keeps behaviour correct for non-power-of-two moduli.
   always_comb begin
      term         = iUP_DOWN ? MaxCount : '0;
      at_term      = (count_q == term);
      load_clamped = (iLOAD_VALUE <= MaxCount) ? iLOAD_VALUE : MaxCount;
   end

   always_comb begin
      count_d    = count_q;
      overflow_d = overflow_q;
      if (iCLEAR) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (iLOAD) begin
         count_d = load_clamped;
      end else if (iENABLE) begin
         if (at_term) begin
            overflow_d = 1'b1;
            if (!iSATURATE) begin
               count_d = iUP_DOWN ? '0 : MaxCount;
            end
         end else begin
            count_d = iUP_DOWN ? count_q + 1'b1 : count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge iCLOCK or negedge iRESET_n) begin
      if (!iRESET_n) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign oCOUNT    = count_q;
   assign oOVERFLOW = overflow_q;
   assign oTC       = iENABLE & at_term;

endmodule
